// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_param
// Brief    : Single-clock FIFO with registered read data, occupancy level,
//            registered threshold flags and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       write,
    input  logic [WIDTH-1:0]           write_d,
    input  logic                       read,
    output logic [WIDTH-1:0]           read_d,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [c_LW-1:0] c_DEPTH = c_LW'(DEPTH);
    localparam logic [c_LW-1:0] c_AF    = c_LW'(AF_LEVEL);
    localparam logic [c_LW-1:0] c_AE    = c_LW'(AE_LEVEL);
    localparam logic [c_LW-1:0] c_ONE   = c_LW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic [WIDTH-1:0] r_read_d;
    logic             r_empty;
    logic             r_full;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [c_LW-1:0]  w_level_nxt;

    // A write into a full FIFO is only accepted when a read frees a slot in
    // the same cycle; reads never bypass from the write port.
    assign w_rd_acc  = read && (r_level != '0);
    assign w_wr_acc  = write && ((r_level != c_DEPTH) || w_rd_acc);
    assign w_ovf_set = write && !w_wr_acc;
    assign w_unf_set = read && (r_level == '0);

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + c_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_level_nxt = r_level - c_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_wr_acc) begin
            r_mem[r_wr_ptr] <= write_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_read_d       <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_full  <= (c_AF == '0);
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_read_d <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level        <= w_level_nxt;
            r_empty        <= (w_level_nxt == '0);
            r_full         <= (w_level_nxt == c_DEPTH);
            r_almost_full  <= (w_level_nxt >= c_AF);
            r_almost_empty <= (w_level_nxt <= c_AE);
            // Set has priority over clear.
            r_overflow     <= w_ovf_set || (r_overflow && !clr_err);
            r_underflow    <= w_unf_set || (r_underflow && !clr_err);
        end
    end

    assign read_d       = r_read_d;
    assign level        = r_level;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
